// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and RAM-side signals for mem_arbiter.
// slave is the arbiter's view; master is the requesters'/RAM's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_ack_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic              x_req_i;
  logic              x_we_i;
  logic [ADDR_W-1:0] x_addr_i;
  logic [DATA_W-1:0] x_wdata_i;
  logic              x_ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_data_i;

  modport slave (
    input  f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           x_req_i, x_we_i, x_addr_i, x_wdata_i, ram_data_i,
    output f_ack_o, d_ack_o, x_ack_o, rdata_o, grant_o, busy_o,
           ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           x_req_i, x_we_i, x_addr_i, x_wdata_i, ram_data_i,
    input  f_ack_o, d_ack_o, x_ack_o, rdata_o, grant_o, busy_o,
           ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between fetch, data and
// debug requesters, with a fixed RAM read latency of READ_LAT cycles.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [3:0]        req_vec;
  logic [1:0]        winner;

  assign req_vec = {1'b0, bus.x_req_i, bus.d_req_i, bus.f_req_i};

  // Search order starts just after the previous owner.
  always_comb begin
    logic [1:0] c0, c1, c2;
    case (last_q)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req_vec[c0])      winner = c0;
    else if (req_vec[c1]) winner = c1;
    else                  winner = c2;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack_d   = 3'b000;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          grant_d = winner;
          last_d  = winner;
          state_d = ISSUE;
          case (winner)
            2'd0: begin addr_d = bus.f_addr_i; we_d = 1'b0;       wdata_d = '0;            end
            2'd1: begin addr_d = bus.d_addr_i; we_d = bus.d_we_i; wdata_d = bus.d_wdata_i; end
            default: begin addr_d = bus.x_addr_i; we_d = bus.x_we_i; wdata_d = bus.x_wdata_i; end
          endcase
        end else begin
          grant_d = 2'd3;
        end
      end
      ISSUE: begin
        we_d = 1'b0;
        if (we_q) begin
          state_d = DONE;
          ack_d   = 3'b001 << grant_q;
        end else if (READ_LAT <= 1) begin
          rdata_d = bus.ram_data_i;
          state_d = DONE;
          ack_d   = 3'b001 << grant_q;
        end else begin
          cnt_d   = 3'(READ_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = bus.ram_data_i;
          state_d = DONE;
          ack_d   = 3'b001 << grant_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'd3;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      grant_q <= 2'd3;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.f_ack_o     = ack_q[0];
  assign bus.d_ack_o     = ack_q[1];
  assign bus.x_ack_o     = ack_q[2];
  assign bus.rdata_o     = rdata_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;
  assign bus.ram_we_o    = we_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one READ_LAT=1 and one READ_LAT=3 instance.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  // Read-only RAM contents for the READ_LAT=1 instance, plus a write capture.
  always_comb begin
    case (b1.ram_addr_o)
      32'h100: b1.ram_data_i = 32'h00500093;
      32'h104: b1.ram_data_i = 32'h12345678;
      32'h040: b1.ram_data_i = 32'h0A0B0C0D;
      32'h020: b1.ram_data_i = 32'hCAFEF00D;
      32'h024: b1.ram_data_i = 32'hBAADBAAD;
      default: b1.ram_data_i = 32'h0;
    endcase
  end

  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  int          wr_count = 0;
  always @(posedge clk) begin
    if (b1.ram_we_o) begin
      wr_addr  <= b1.ram_addr_o;
      wr_data  <= b1.ram_wdata_o;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tests++; if (b1.grant_o !== 2'd3) begin failed++; $display("FAIL reset_grant: got %0d expected 3", b1.grant_o); end
    tests++; if ({b1.f_ack_o, b1.d_ack_o, b1.x_ack_o} !== 3'b000) begin failed++; $display("FAIL reset_acks: got %b expected 000", {b1.f_ack_o, b1.d_ack_o, b1.x_ack_o}); end
    tests++; if ({b1.ram_we_o, b1.busy_o} !== 2'b00) begin failed++; $display("FAIL reset_we_busy: got %b expected 00", {b1.ram_we_o, b1.busy_o}); end
    tests++; if (b1.ram_addr_o !== 32'h0 || b1.ram_wdata_o !== 32'h0 || b1.rdata_o !== 32'h0) begin failed++; $display("FAIL reset_data: got addr %h wdata %h rdata %h expected all 0", b1.ram_addr_o, b1.ram_wdata_o, b1.rdata_o); end
    $display("[TB] reset done");
  endtask

  task automatic test_fetch;
    b1.f_req_i = 1'b1; b1.f_addr_i = 32'h100;
    tick();
    tests++; if (b1.ram_addr_o !== 32'h100 || b1.ram_we_o !== 1'b0) begin failed++; $display("FAIL fetch_issue: got addr %h we %b expected 100 0", b1.ram_addr_o, b1.ram_we_o); end
    tests++; if (b1.grant_o !== 2'd0 || b1.busy_o !== 1'b1 || b1.f_ack_o !== 1'b0) begin failed++; $display("FAIL fetch_issue_ctl: got grant %0d busy %b ack %b expected 0 1 0", b1.grant_o, b1.busy_o, b1.f_ack_o); end
    tick();
    tests++; if (b1.f_ack_o !== 1'b1 || b1.rdata_o !== 32'h00500093 || b1.grant_o !== 2'd0) begin failed++; $display("FAIL fetch_done: got ack %b rdata %h grant %0d expected 1 00500093 0", b1.f_ack_o, b1.rdata_o, b1.grant_o); end
    b1.f_req_i = 1'b0;
    tick();
    tests++; if (b1.grant_o !== 2'd3 || b1.f_ack_o !== 1'b0 || b1.busy_o !== 1'b0) begin failed++; $display("FAIL fetch_idle: got grant %0d ack %b busy %b expected 3 0 0", b1.grant_o, b1.f_ack_o, b1.busy_o); end
    $display("[TB] fetch 0x100 -> rdata %h", b1.rdata_o);
  endtask

  task automatic test_store;
    b1.d_req_i = 1'b1; b1.d_we_i = 1'b1; b1.d_addr_i = 32'h40; b1.d_wdata_i = 32'hDEADBEEF;
    tick();
    tests++; if (b1.ram_we_o !== 1'b1 || b1.ram_addr_o !== 32'h40 || b1.ram_wdata_o !== 32'hDEADBEEF) begin failed++; $display("FAIL store_issue: got we %b addr %h wdata %h expected 1 40 deadbeef", b1.ram_we_o, b1.ram_addr_o, b1.ram_wdata_o); end
    tests++; if (b1.grant_o !== 2'd1 || b1.d_ack_o !== 1'b0) begin failed++; $display("FAIL store_issue_ctl: got grant %0d ack %b expected 1 0", b1.grant_o, b1.d_ack_o); end
    tick();
    tests++; if (b1.ram_we_o !== 1'b0 || b1.d_ack_o !== 1'b1 || b1.rdata_o !== 32'h00500093) begin failed++; $display("FAIL store_done: got we %b ack %b rdata %h expected 0 1 00500093", b1.ram_we_o, b1.d_ack_o, b1.rdata_o); end
    b1.d_req_i = 1'b0; b1.d_we_i = 1'b0;
    tick();
    tests++; if (b1.d_ack_o !== 1'b0 || wr_count !== 1 || wr_addr !== 32'h40 || wr_data !== 32'hDEADBEEF) begin failed++; $display("FAIL store_write: got ack %b writes %0d addr %h data %h expected 0 1 40 deadbeef", b1.d_ack_o, wr_count, wr_addr, wr_data); end
    $display("[TB] store 0x40 <- deadbeef");
  endtask

  task automatic test_round_robin;
    int          exp_g [6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] exp_r [3] = '{32'h00500093, 32'h0A0B0C0D, 32'h12345678};
    reset = 1'b0;
    tick();
    reset = 1'b1;
    b1.f_req_i = 1'b1; b1.f_addr_i = 32'h100;
    b1.d_req_i = 1'b1; b1.d_we_i = 1'b0; b1.d_addr_i = 32'h40;
    b1.x_req_i = 1'b1; b1.x_we_i = 1'b0; b1.x_addr_i = 32'h104;
    for (int g = 0; g < 6; g++) begin
      tick();
      tests++; if (b1.grant_o !== 2'(exp_g[g])) begin failed++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", g, b1.grant_o, exp_g[g]); end
      tick();
      tests++; if ({b1.x_ack_o, b1.d_ack_o, b1.f_ack_o} !== 3'(1 << exp_g[g]) || b1.rdata_o !== exp_r[exp_g[g]]) begin failed++; $display("FAIL rr_done[%0d]: got acks %b rdata %h expected %b %h", g, {b1.x_ack_o, b1.d_ack_o, b1.f_ack_o}, b1.rdata_o, 3'(1 << exp_g[g]), exp_r[exp_g[g]]); end
      if (g == 5) begin b1.f_req_i = 1'b0; b1.d_req_i = 1'b0; b1.x_req_i = 1'b0; end
      tick();
      tests++; if ({b1.x_ack_o, b1.d_ack_o, b1.f_ack_o} !== 3'b000) begin failed++; $display("FAIL rr_idle_acks[%0d]: got %b expected 000", g, {b1.x_ack_o, b1.d_ack_o, b1.f_ack_o}); end
      $display("[TB] rr grant %0d -> port %0d rdata %h", g, exp_g[g], exp_r[exp_g[g]]);
    end
    tests++; if (b1.grant_o !== 2'd3 || b1.busy_o !== 1'b0) begin failed++; $display("FAIL rr_end: got grant %0d busy %b expected 3 0", b1.grant_o, b1.busy_o); end
  endtask

  task automatic test_lat3;
    b3.f_req_i = 1'b1; b3.f_addr_i = 32'h8; b3.ram_data_i = 32'h0BAD0000;
    tick();
    tests++; if (b3.ram_addr_o !== 32'h8 || b3.grant_o !== 2'd0 || b3.f_ack_o !== 1'b0) begin failed++; $display("FAIL lat3_issue: got addr %h grant %0d ack %b expected 8 0 0", b3.ram_addr_o, b3.grant_o, b3.f_ack_o); end
    b3.ram_data_i = 32'h11111111;
    tick();
    tests++; if (b3.ram_addr_o !== 32'h8 || b3.f_ack_o !== 1'b0 || b3.rdata_o !== 32'h0) begin failed++; $display("FAIL lat3_wait1: got addr %h ack %b rdata %h expected 8 0 0", b3.ram_addr_o, b3.f_ack_o, b3.rdata_o); end
    b3.ram_data_i = 32'h22222222;
    tick();
    tests++; if (b3.ram_addr_o !== 32'h8 || b3.f_ack_o !== 1'b0 || b3.busy_o !== 1'b1) begin failed++; $display("FAIL lat3_wait2: got addr %h ack %b busy %b expected 8 0 1", b3.ram_addr_o, b3.f_ack_o, b3.busy_o); end
    b3.ram_data_i = 32'h33333333;
    tick();
    tests++; if (b3.f_ack_o !== 1'b1 || b3.rdata_o !== 32'h33333333) begin failed++; $display("FAIL lat3_done: got ack %b rdata %h expected 1 33333333", b3.f_ack_o, b3.rdata_o); end
    b3.f_req_i = 1'b0; b3.ram_data_i = 32'h44444444;
    tick();
    tests++; if (b3.grant_o !== 2'd3 || b3.f_ack_o !== 1'b0 || b3.rdata_o !== 32'h33333333) begin failed++; $display("FAIL lat3_idle: got grant %0d ack %b rdata %h expected 3 0 33333333", b3.grant_o, b3.f_ack_o, b3.rdata_o); end
    $display("[TB] lat3 read 0x8 -> rdata %h", b3.rdata_o);
  endtask

  task automatic test_reset_wait;
    b3.x_req_i = 1'b1; b3.x_we_i = 1'b0; b3.x_addr_i = 32'h10; b3.ram_data_i = 32'h55555555;
    tick();
    tests++; if (b3.grant_o !== 2'd2) begin failed++; $display("FAIL rstw_grant: got %0d expected 2", b3.grant_o); end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++; if (b3.busy_o !== 1'b0 || b3.grant_o !== 2'd3 || b3.x_ack_o !== 1'b0 || b3.rdata_o !== 32'h0) begin failed++; $display("FAIL rstw_abort: got busy %b grant %0d ack %b rdata %h expected 0 3 0 0", b3.busy_o, b3.grant_o, b3.x_ack_o, b3.rdata_o); end
    tick(); tick(); tick();
    tests++; if (b3.x_ack_o !== 1'b0 || b3.busy_o !== 1'b1) begin failed++; $display("FAIL rstw_wait: got ack %b busy %b expected 0 1", b3.x_ack_o, b3.busy_o); end
    tick();
    tests++; if (b3.x_ack_o !== 1'b1 || b3.rdata_o !== 32'h55555555 || b3.grant_o !== 2'd2) begin failed++; $display("FAIL rstw_reissue: got ack %b rdata %h grant %0d expected 1 55555555 2", b3.x_ack_o, b3.rdata_o, b3.grant_o); end
    b3.x_req_i = 1'b0;
    tick();
    $display("[TB] reset during wait, reissue -> rdata %h", b3.rdata_o);
  endtask

  task automatic test_operand_hold;
    b1.d_req_i = 1'b1; b1.d_we_i = 1'b0; b1.d_addr_i = 32'h20;
    tick();
    tests++; if (b1.ram_addr_o !== 32'h20) begin failed++; $display("FAIL opnd_issue: got addr %h expected 20", b1.ram_addr_o); end
    b1.d_addr_i = 32'h24;
    tick();
    tests++; if (b1.ram_addr_o !== 32'h20 || b1.d_ack_o !== 1'b1 || b1.rdata_o !== 32'hCAFEF00D) begin failed++; $display("FAIL opnd_done: got addr %h ack %b rdata %h expected 20 1 cafef00d", b1.ram_addr_o, b1.d_ack_o, b1.rdata_o); end
    b1.d_req_i = 1'b0;
    tick();
    tests++; if (b1.d_ack_o !== 1'b0 || b1.grant_o !== 2'd3) begin failed++; $display("FAIL opnd_idle: got ack %b grant %0d expected 0 3", b1.d_ack_o, b1.grant_o); end
    $display("[TB] operand change after grant -> addr %h", b1.ram_addr_o);
  endtask

  initial begin
    b1.f_req_i = 0; b1.f_addr_i = 0; b1.d_req_i = 0; b1.d_we_i = 0; b1.d_addr_i = 0; b1.d_wdata_i = 0;
    b1.x_req_i = 0; b1.x_we_i = 0; b1.x_addr_i = 0; b1.x_wdata_i = 0;
    b3.f_req_i = 0; b3.f_addr_i = 0; b3.d_req_i = 0; b3.d_we_i = 0; b3.d_addr_i = 0; b3.d_wdata_i = 0;
    b3.x_req_i = 0; b3.x_we_i = 0; b3.x_addr_i = 0; b3.x_wdata_i = 0; b3.ram_data_i = 0;
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_lat3();
    test_reset_wait();
    test_operand_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
